adc_corrector: RTL

//  Receive-side counterpart of the DAC output formatter. Converts raw offset-binary ADC

---
 rtl/adc_corrector_pkg.sv | 10 +
 rtl/adc_dc_blocker.sv | 33 +++
 rtl/adc_corrector.sv | 69 ++++++
 3 files changed

// File: rtl/adc_corrector_pkg.sv
// adc_corrector_pkg: transceiver constants shared by the RX corrector and TX formatter,
// plus the overflow test used when saturating a one-bit-wider result.
package adc_corrector_pkg;
  localparam int ADC_W_DEF     = 16;
  localparam int DC_SHIFT_DEF  = 12;
  localparam int CLIP_HOLD_DEF = 4096;
  function automatic logic sat_ovf(input logic guard, input logic msb);
    return guard ^ msb;
  endfunction
endpackage

// File: rtl/adc_dc_blocker.sv
// adc_dc_blocker: subtracts the leaky DC estimate (acc >>> DC_SHIFT), saturates, and
// accumulates the saturated output; a low enable bypasses and clears the accumulator.
module adc_dc_blocker import adc_corrector_pkg::*; #(
  parameter int ADC_W    = ADC_W_DEF,
  parameter int DC_SHIFT = DC_SHIFT_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic [ADC_W-1:0] x,
  output logic [ADC_W-1:0] y
);
  localparam int AW = ADC_W + DC_SHIFT;
  logic [AW-1:0]    acc_q, acc_d;
  logic [ADC_W-1:0] est, y_q, y_d;
  logic [ADC_W:0]   diff;
  // the top ADC_W bits of acc are exactly acc >>> DC_SHIFT
  assign est = acc_q[AW-1:DC_SHIFT];
  assign y   = y_q;
  always_comb begin
    diff  = {x[ADC_W-1], x} - (en ? {est[ADC_W-1], est} : '0);
    y_d   = sat_ovf(diff[ADC_W], diff[ADC_W-1]) ? {diff[ADC_W], {(ADC_W-1){~diff[ADC_W]}}} : diff[ADC_W-1:0];
    acc_d = en ? acc_q + {{DC_SHIFT{y_d[ADC_W-1]}}, y_d} : '0;
  end
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
endmodule

// File: rtl/adc_corrector.sv
// adc_corrector: offset-binary ADC to signed samples with DC blocking, held overload flag
// and peak meter. Define ADC_RANDOMIZER_EN to undo LTC22xx output randomization in S1.
module adc_corrector import adc_corrector_pkg::*; #(
  parameter int ADC_W     = ADC_W_DEF,
  parameter int DC_SHIFT  = DC_SHIFT_DEF,
  parameter int CLIP_HOLD = CLIP_HOLD_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [ADC_W-1:0] ADC_INPUT,
  input  logic             ADC_OTR,
  input  logic             DC_FILTER_ENABLE,
  input  logic             PEAK_CLEAR,
  output logic [ADC_W-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic             ADC_OVERLOAD,
  output logic [ADC_W-2:0] ADC_PEAK
);
  localparam int HW = $clog2(CLIP_HOLD + 1);
  localparam logic [ADC_W-1:0] MID = {1'b1, {(ADC_W-1){1'b0}}};
  logic [ADC_W-1:0] r_q, r_d, s_q, s_d;
  logic             otr_q, clip_q, clip_d;
  logic [HW-1:0]    cnt_q, cnt_d;
  logic [1:0]       fill_q, fill_d;
  logic [ADC_W-2:0] peak_q, peak_d, mag;
`ifdef ADC_RANDOMIZER_EN
  assign r_d = {ADC_INPUT[ADC_W-1:1] ^ {(ADC_W-1){ADC_INPUT[0]}}, ADC_INPUT[0]};
`else
  assign r_d = ADC_INPUT;
`endif
  assign DATA_VALID   = &fill_q;
  assign ADC_OVERLOAD = cnt_q != '0;
  assign ADC_PEAK     = peak_q;
  always_comb begin
    s_d    = {~r_q[ADC_W-1], r_q[ADC_W-2:0]};
    clip_d = otr_q | ~|r_q | &r_q;
    cnt_d  = clip_q ? HW'(CLIP_HOLD) : cnt_q - HW'(cnt_q != '0);
    fill_d = fill_q + 2'(fill_q != 2'd3);
    // |most negative| has no positive twin, so it reads as full scale
    mag    = !DATA_OUT[ADC_W-1] ? DATA_OUT[ADC_W-2:0] :
             DATA_OUT[ADC_W-2:0] == '0 ? '1 : ~DATA_OUT[ADC_W-2:0] + (ADC_W-1)'(1);
    peak_d = (PEAK_CLEAR && DATA_VALID) ? mag : (mag > peak_q ? mag : peak_q);
  end
  always_ff @(posedge clk_in or negedge reset_n)
    if (!reset_n) begin
      r_q    <= MID;
      otr_q  <= 1'b0;
      s_q    <= '0;
      clip_q <= 1'b0;
      cnt_q  <= '0;
      fill_q <= '0;
      peak_q <= '0;
    end else begin
      r_q    <= r_d;
      otr_q  <= ADC_OTR;
      s_q    <= s_d;
      clip_q <= clip_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      peak_q <= peak_d;
    end
  adc_dc_blocker #(.ADC_W(ADC_W), .DC_SHIFT(DC_SHIFT)) u_dc (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .en     (DC_FILTER_ENABLE),
    .x      (s_q),
    .y      (DATA_OUT)
  );
endmodule
